hc_wide_add_seq: RTL and testbench

//  Multi-cycle sequencer that runs one 16-bit Han-Carlson prefix adder core over

---
 rtl/hc_wide_add_seq.sv | 172 +++++++++++++++++
 tb/tb_hc_wide_add_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_wide_add_seq.sv
// Wide add/sub sequencer: one 16-bit Han-Carlson core is reused over NCHUNK
// slices, rippling the carry through a register between cycles.

module hc_add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] s_o,
    output logic        cout_o
);
    logic [15:0]      prop;
    logic [5:0][15:0] g;
    logic [5:0][15:0] p;

    // Odd bits form a Kogge-Stone tree; even bits resolve in one extra level.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        g    = '0;
        p    = '0;
        prop = a_i ^ b_i;
        g[0] = a_i & b_i;
        p[0] = prop;
        g[0][0] = g[0][0] | (p[0][0] & cin_i);
        for (int lvl = 1; lvl <= 4; lvl++) begin
            g[lvl] = g[lvl-1];
            p[lvl] = p[lvl-1];
            for (int i = 1; i < 16; i += 2) begin
                if (i >= (1 << (lvl - 1))) begin
                    g[lvl][i] = g[lvl-1][i] | (p[lvl-1][i] & g[lvl-1][i - (1 << (lvl - 1))]);
                    p[lvl][i] = p[lvl-1][i] & p[lvl-1][i - (1 << (lvl - 1))];
                end
            end
        end
        g[5] = g[4];
        p[5] = p[4];
        for (int i = 2; i < 16; i += 2) begin
            g[5][i] = g[4][i] | (p[4][i] & g[4][i-1]);
        end
    end

    assign s_o    = prop ^ {g[5][14:0], cin_i};
    assign cout_o = g[5][15];
endmodule

module hc_wide_add_seq #(
    parameter int NCHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*NCHUNK-1:0] in_a,
    input  logic [16*NCHUNK-1:0] in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*NCHUNK-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic                 busy
);
    localparam int DW = 16 * NCHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [15:0]   a_sl, b_sl, core_s;
    logic          core_cout;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                a_sl = a_q[16*k +: 16];
                b_sl = b_q[16*k +: 16];
            end
        end
    end

    hc_add16 u_core (
        .a_i    (a_sl),
        .b_i    (b_sl),
        .cin_i  (carry_q),
        .s_o    (core_s),
        .cout_o (core_cout)
    );

    // B is stored already inverted for subtraction, so RUN only ever adds.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (cnt_q == CW'(k)) sum_d[16*k +: 16] = core_s;
                end
                carry_d = core_cout;
                if (cnt_q == CNT_LAST) begin
                    cout_d  = core_cout;
                    ovf_d   = (a_q[DW-1] == b_q[DW-1]) && (core_s[15] != a_q[DW-1]);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: operand and result registers are reset too, so outputs read as zero right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the same pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_hc_wide_add_seq.sv
// Directed and randomized checks of hc_wide_add_seq at NCHUNK=4 and NCHUNK=1
// against a plain-arithmetic reference model.

module tb_hc_wide_add_seq;
    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Index 0 drives the NCHUNK=4 instance, index 1 the NCHUNK=1 instance.
    logic [63:0] a_drv [2];
    logic [63:0] b_drv [2];
    logic        vld_drv [2];
    logic        cin_drv [2];
    logic        sub_drv [2];
    logic        ordy_drv [2];

    logic        obs_rdy [2];
    logic        obs_vld [2];
    logic        obs_cout [2];
    logic        obs_ovf [2];
    logic        obs_busy [2];
    logic [63:0] obs_sum [2];

    logic [63:0] s4;
    logic [15:0] s1;

    hc_wide_add_seq #(.NCHUNK(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vld_drv[0]),
        .in_ready  (obs_rdy[0]),
        .in_a      (a_drv[0]),
        .in_b      (b_drv[0]),
        .in_cin    (cin_drv[0]),
        .in_sub    (sub_drv[0]),
        .out_valid (obs_vld[0]),
        .out_ready (ordy_drv[0]),
        .out_sum   (s4),
        .out_cout  (obs_cout[0]),
        .out_ovf   (obs_ovf[0]),
        .busy      (obs_busy[0])
    );

    hc_wide_add_seq #(.NCHUNK(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vld_drv[1]),
        .in_ready  (obs_rdy[1]),
        .in_a      (a_drv[1][15:0]),
        .in_b      (b_drv[1][15:0]),
        .in_cin    (cin_drv[1]),
        .in_sub    (sub_drv[1]),
        .out_valid (obs_vld[1]),
        .out_ready (ordy_drv[1]),
        .out_sum   (s1),
        .out_cout  (obs_cout[1]),
        .out_ovf   (obs_ovf[1]),
        .busy      (obs_busy[1])
    );

    assign obs_sum[0] = s4;
    assign obs_sum[1] = {48'd0, s1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: unsigned sum/borrow and signed range test on n*16-bit values.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input int n);
        int                 dw;
        logic [66:0]        m, ua, ub, u;
        logic signed [66:0] sa, sb, exact, lim;
        res_t               r;
        dw    = 16 * n;
        m     = (67'd1 << dw) - 67'd1;
        ua    = {3'b0, a} & m;
        ub    = {3'b0, b} & m;
        sa    = ua[dw-1] ? $signed(ua | ~m) : $signed(ua);
        sb    = ub[dw-1] ? $signed(ub | ~m) : $signed(ub);
        lim   = 67'sd1 <<< (dw - 1);
        if (sub) begin
            exact  = sa - sb;
            u      = ua - ub;
            r.cout = (ua >= ub);
        end else begin
            exact  = sa + sb + $signed({66'd0, cin});
            u      = ua + ub + {66'd0, cin};
            r.cout = (u > m);
        end
        r.sum = 64'(u & m);
        r.ovf = (exact >= lim) || (exact < -lim);
        return r;
    endfunction

    function automatic logic [63:0] rand_opnd();
        logic [63:0] v;
        for (int s = 0; s < 4; s++) begin
            case ($urandom_range(4))
                0:       v[16*s +: 16] = 16'h0000;
                1:       v[16*s +: 16] = 16'hFFFF;
                2:       v[16*s +: 16] = 16'h8000;
                3:       v[16*s +: 16] = 16'h7FFF;
                default: v[16*s +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    int   acc_cyc [2];
    int   done_n [2];
    bit   seen [2];
    res_t q0 [$];
    res_t q1 [$];

    task automatic issue0(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        @(negedge clk);
        check("issue_in_ready", 64'(obs_rdy[0]), 64'd1);
        a_drv[0]   = a;
        b_drv[0]   = b;
        cin_drv[0] = cin;
        sub_drv[0] = sub;
        vld_drv[0] = 1'b1;
        acc_cyc[0] = cyc + 1;
        @(negedge clk);
        vld_drv[0] = 1'b0;
    endtask

    task automatic wait_done0(output int lat);
        int k = 0;
        while (!obs_vld[0] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", 64'(obs_vld[0]), 64'd1);
        lat = cyc - acc_cyc[0];
    endtask

    task automatic release0();
        ordy_drv[0] = 1'b1;
        @(negedge clk);
        ordy_drv[0] = 1'b0;
        check("back_idle_rdy", 64'(obs_rdy[0]), 64'd1);
        check("back_idle_vld", 64'(obs_vld[0]), 64'd0);
    endtask

    task automatic dir_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub,
                          input logic [63:0] esum, input logic ecout, input logic eovf);
        int lat;
        issue0(a, b, cin, sub);
        wait_done0(lat);
        check({tag, "_sum"},  obs_sum[0], esum);
        check({tag, "_cout"}, 64'(obs_cout[0]), 64'(ecout));
        check({tag, "_ovf"},  64'(obs_ovf[0]), 64'(eovf));
        check({tag, "_lat"},  64'(lat), 64'd4);
        release0();
    endtask

    task automatic rand_step(input int k);
        int          n;
        logic [63:0] m;
        res_t        e;
        int          qs;
        n  = (k == 0) ? 4 : 1;
        m  = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
        qs = (k == 0) ? q0.size() : q1.size();
        if (obs_vld[k]) begin
            if (qs == 0) begin
                check($sformatf("rand%0d_unexpected_vld", n), 64'(obs_vld[k]), 64'd0);
            end else begin
                e = (k == 0) ? q0[0] : q1[0];
                check($sformatf("rand%0d_sum", n),  obs_sum[k], e.sum);
                check($sformatf("rand%0d_cout", n), 64'(obs_cout[k]), 64'(e.cout));
                check($sformatf("rand%0d_ovf", n),  64'(obs_ovf[k]), 64'(e.ovf));
                if (!seen[k]) begin
                    check($sformatf("rand%0d_lat", n), 64'(cyc - acc_cyc[k]), 64'(n));
                    seen[k] = 1'b1;
                end
            end
        end
        ordy_drv[k] = ($urandom_range(3) != 0);
        if (obs_vld[k] && ordy_drv[k] && qs > 0) begin
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            done_n[k]++;
            seen[k] = 1'b0;
        end
        vld_drv[k] = ($urandom_range(3) != 0);
        a_drv[k]   = rand_opnd() & m;
        b_drv[k]   = rand_opnd() & m;
        cin_drv[k] = 1'($urandom_range(1));
        sub_drv[k] = 1'($urandom_range(1));
        if (obs_rdy[k] && vld_drv[k]) begin
            e = model(a_drv[k], b_drv[k], cin_drv[k], sub_drv[k], n);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            acc_cyc[k] = cyc + 1;
        end
    endtask

    initial begin
        res_t e;
        int   lat;
        for (int k = 0; k < 2; k++) begin
            a_drv[k] = '0; b_drv[k] = '0; vld_drv[k] = 1'b0;
            cin_drv[k] = 1'b0; sub_drv[k] = 1'b0; ordy_drv[k] = 1'b0;
            acc_cyc[k] = 0; done_n[k] = 0; seen[k] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_out_valid", 64'(obs_vld[k]), 64'd0);
            check("rst_busy",      64'(obs_busy[k]), 64'd0);
            check("rst_sum",       obs_sum[k], 64'd0);
            check("rst_cout",      64'(obs_cout[k]), 64'd0);
            check("rst_ovf",       64'(obs_ovf[k]), 64'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(obs_rdy[0]), 64'd1);

        dir_op("t1",  64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        dir_op("t2",  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        dir_op("t3",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        dir_op("t4a", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        dir_op("t4b", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Stall in DONE while in_valid pulses must be ignored.
        e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 4);
        issue0(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
        wait_done0(lat);
        for (int i = 0; i < 10; i++) begin
            vld_drv[0] = i[0];
            a_drv[0]   = {$urandom, $urandom};
            @(negedge clk);
            check("stall_vld",  64'(obs_vld[0]), 64'd1);
            check("stall_rdy",  64'(obs_rdy[0]), 64'd0);
            check("stall_sum",  obs_sum[0], e.sum);
            check("stall_cout", 64'(obs_cout[0]), 64'(e.cout));
            check("stall_ovf",  64'(obs_ovf[0]), 64'(e.ovf));
        end
        vld_drv[0] = 1'b0;
        release0();
        @(negedge clk);
        check("stall_no_accept", 64'(obs_busy[0]), 64'd0);

        // Asynchronous reset in the middle of RUN.
        issue0(64'h0000_0000_0000_1234, 64'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_vld",  64'(obs_vld[0]), 64'd0);
        check("arst_busy", 64'(obs_busy[0]), 64'd0);
        check("arst_sum",  obs_sum[0], 64'd0);
        check("arst_cout", 64'(obs_cout[0]), 64'd0);
        check("arst_ovf",  64'(obs_ovf[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_rdy", 64'(obs_rdy[0]), 64'd1);
        dir_op("t6", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);

        // Random traffic on both instances simultaneously.
        for (int t = 0; t < 40000 && !(done_n[0] >= 2000 && done_n[1] >= 2000); t++) begin
            @(negedge clk);
            rand_step(0);
            rand_step(1);
        end
        check("rand4_ops_done", 64'(done_n[0] >= 2000), 64'd1);
        check("rand1_ops_done", 64'(done_n[1] >= 2000), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
